// File: rtl/data_ram64_pkg.sv
// data_ram64_pkg: shared sizing constants for the 64 x 32 data memory
package data_ram64_pkg;
  localparam int DFLT_DATA_W = 32;
  localparam int DFLT_ADDR_W = 6;
  localparam int RAM_DEPTH = 2 ** DFLT_ADDR_W;
endpackage

// File: rtl/data_ram64.sv
// data_ram64: single-port word-addressed data memory, sync write, registered read-first read
module data_ram64
  import data_ram64_pkg::*;
#(
  parameter int DATA_W = DFLT_DATA_W,
  parameter int ADDR_W = DFLT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              enable_read,
  input  logic              enable_write,
  input  logic [DATA_W-1:0] DMin,
  output logic [DATA_W-1:0] DMout
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] RAM_Data [0:DEPTH-1];
  // read samples pre-edge contents, so a same-address write returns the old word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) RAM_Data[i] <= '0;
      DMout <= '0;
    end else begin
      if (enable_write) RAM_Data[address] <= DMin;
      if (enable_read) DMout <= RAM_Data[address];
    end
  end
endmodule

// File: tb/tb_data_ram64.sv
// tb_data_ram64: scoreboard bench for data_ram64 with a behavioural read-first model
module tb_data_ram64;
  import data_ram64_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DFLT_ADDR_W-1:0] address = '0;
  logic enable_read = 1'b0;
  logic enable_write = 1'b0;
  logic [DFLT_DATA_W-1:0] DMin = '0;
  logic [DFLT_DATA_W-1:0] DMout;
  logic [DFLT_DATA_W-1:0] model [RAM_DEPTH];
  logic [DFLT_DATA_W-1:0] exp_q [$];
  logic [DFLT_DATA_W-1:0] held;
  int total = 0;
  int bad = 0;
  data_ram64 dut (
    .clk(clk), .rst(rst), .address(address), .enable_read(enable_read),
    .enable_write(enable_write), .DMin(DMin), .DMout(DMout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    enable_read = 1'b0;
    enable_write = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) model[i] = '0;
    held = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out", DMout, 32'h0);
  endtask
  // one clock of stimulus; reads are scored one cycle later, otherwise DMout must hold
  task automatic cyc(input bit rd, input bit wr, input logic [5:0] a, input logic [31:0] d);
    enable_read = rd;
    enable_write = wr;
    address = a;
    DMin = d;
    if (rd) begin
      exp_q.push_back(model[a]);
      held = model[a];
    end
    if (wr) model[a] = d;
    @(posedge clk);
    #1;
    if (rd) check($sformatf("rd_%0d", a), DMout, exp_q.pop_front());
    else check("hold", DMout, held);
    enable_read = 1'b0;
    enable_write = 1'b0;
  endtask
  task automatic dump(input string tag);
    for (int i = 0; i < RAM_DEPTH; i++)
      check($sformatf("%s_%0d", tag, i), dut.RAM_Data[i], model[i]);
  endtask
  initial begin
    logic [5:0] rd0 [5] = '{6'd2, 6'd3, 6'd57, 6'd11, 6'd19};
    logic [5:0] wa [9] = '{6'd0, 6'd31, 6'd4, 6'd7, 6'd9, 6'd6, 6'd40, 6'd37, 6'd63};
    logic [31:0] wd [9] = '{32'h00000afc, 32'h0000b031, 32'hf0000005, 32'h00000246,
                            32'h000000a9, 32'h0000006e, 32'hffffffff, 32'h0000046a, 32'h03c10dd3};
    @(posedge clk);
    #1;
    do_reset();
    foreach (rd0[i]) cyc(1, 0, rd0[i], 0);
    foreach (wa[i]) cyc(0, 1, wa[i], wd[i]);
    cyc(1, 0, 40, 0);
    cyc(1, 0, 63, 0);
    cyc(1, 0, 31, 0);
    check("ref_40", model[40], 32'hffffffff);
    cyc(0, 1, 3, 32'h00000ff5);
    cyc(0, 1, 17, 32'h00ed2a24);
    cyc(1, 0, 3, 0);
    cyc(0, 1, 19, 32'h00000123);
    cyc(1, 0, 17, 0);
    cyc(0, 1, 1, 32'h00000ccc);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 19, 0);
    repeat (3) cyc(0, 0, 0, 0);
    dump("ram");
    cyc(1, 1, 4, 32'h12345678);
    cyc(1, 0, 4, 0);
    do_reset();
    cyc(1, 0, 63, 0);
    cyc(1, 0, 4, 0);
    dump("clr");
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
